// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEFAULT_DEPTH = 256;
    localparam int DEFAULT_AW    = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: masked requesters are ignored, ties go to the
// port that did not win last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic [1:0] eff;

    always_comb begin
        eff   = req & ~mask;
        valid = |eff;
        if (&eff) winner = ~last;
        else      winner = eff[PORT_D];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported word memory between instruction fetch and the
// load/store unit using a req/ack handshake and round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [AW-1:0] i_rdata,
    output logic          i_err,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_ack,
    output logic [AW-1:0] d_rdata,
    output logic          d_err,

    output logic [AW-1:0] mem_address,
    output logic [AW-1:0] mem_write_data,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [AW-1:0] mem_data
);

    state_t        state;
    logic          last;
    logic          cur_err;
    logic          cur_we;
    logic [1:0]    mask;
    logic          pick_valid;
    logic          pick_winner;
    logic          in_range_i;
    logic          in_range_d;
    logic          g_in_range;
    logic          g_we;
    logic [AW-1:0] g_addr;

    assign in_range_i = i_addr < AW'(DEPTH);
    assign in_range_d = d_addr < AW'(DEPTH);

    // In RESP the just-acked requester still holds req, so it must not re-win.
    always_comb begin
        mask = 2'b00;
        if (state == RESP) mask[last] = 1'b1;
    end

    rr_pick2 u_pick (
        .req    ({d_req, i_req}),
        .mask   (mask),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        g_addr     = i_addr;
        g_in_range = in_range_i;
        g_we       = 1'b0;
        if (pick_winner == PORT_D) begin
            g_addr     = d_addr;
            g_in_range = in_range_d;
            g_we       = d_we;
        end
    end

    // NOTE: strobes are registered and cleared by the async reset, so a
    // pending mem_write drops the instant rst_n falls, before any clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last           <= PORT_D;
            cur_err        <= 1'b0;
            cur_we         <= 1'b0;
            i_ack          <= 1'b0;
            i_rdata        <= '0;
            i_err          <= 1'b0;
            d_ack          <= 1'b0;
            d_rdata        <= '0;
            d_err          <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    i_ack          <= 1'b0;
                    d_ack          <= 1'b0;
                    mem_address    <= '0;
                    mem_write_data <= '0;
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b0;
                    if (pick_valid) begin
                        state   <= (pick_winner == PORT_D) ? GNT_D : GNT_I;
                        last    <= pick_winner;
                        cur_we  <= g_we;
                        cur_err <= !g_in_range;
                        if (g_in_range) begin
                            mem_address    <= g_addr;
                            mem_read       <= !g_we;
                            mem_write      <= g_we;
                            mem_write_data <= g_we ? d_wdata : '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                GNT_I, GNT_D: begin
                    mem_address    <= '0;
                    mem_write_data <= '0;
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b0;
                    state          <= RESP;
                    if (last == PORT_D) begin
                        d_ack   <= 1'b1;
                        d_err   <= cur_err;
                        d_rdata <= (cur_err || cur_we) ? '0 : mem_data;
                    end else begin
                        i_ack   <= 1'b1;
                        i_err   <= cur_err;
                        i_rdata <= cur_err ? '0 : mem_data;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-word memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_ack, i_err;
    logic [AW-1:0] i_addr, i_rdata;
    logic          d_req, d_we, d_ack, d_err;
    logic [AW-1:0] d_addr, d_wdata, d_rdata;
    logic [AW-1:0] mem_address, mem_write_data, mem_data;
    logic          mem_read, mem_write;

    logic [AW-1:0] mem [DEPTH];
    logic [AW-1:0] snap [DEPTH];
    logic          pre_we;
    logic [7:0]    pre_addr;
    logic [AW-1:0] pre_data;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ack          (i_ack),
        .i_rdata        (i_rdata),
        .i_err          (i_err),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ack          (d_ack),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_data       (mem_data)
    );

    // Memory model: combinational read, write on the rising edge.
    assign mem_data = (mem_address < AW'(DEPTH)) ? mem[mem_address[7:0]] : '0;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_write && mem_address < AW'(DEPTH))
            mem[mem_address[7:0]] <= mem_write_data;
    end

    task automatic preload(input logic [7:0] a, input logic [AW-1:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({i_ack, i_err, d_ack, d_err, mem_read, mem_write} !== 6'b0) begin
            n_fails++; $display("FAIL reset_flags: got %b want 000000", {i_ack, i_err, d_ack, d_err, mem_read, mem_write});
        end
        n_checks++;
        if ({i_rdata, d_rdata, mem_address, mem_write_data} !== '0) begin
            n_fails++; $display("FAIL reset_buses: got %h want 0", {i_rdata, d_rdata, mem_address, mem_write_data});
        end
    endtask

    task automatic test_single_fetch;
        i_req = 1'b1; i_addr = 32'd5;
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, i_ack} !== 3'b100 || mem_address !== 32'd5) begin
            n_fails++; $display("FAIL fetch_strobe: rd/wr/ack=%b addr=%0d want 100 addr=5", {mem_read, mem_write, i_ack}, mem_address);
        end
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hDEADBEEF || i_err !== 1'b0 || mem_read !== 1'b0) begin
            n_fails++; $display("FAIL fetch_ack: ack=%b data=%h err=%b rd=%b want 1 deadbeef 0 0", i_ack, i_rdata, i_err, mem_read);
        end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            n_fails++; $display("FAIL fetch_hold: ack=%b data=%h want 0 deadbeef", i_ack, i_rdata);
        end
    endtask

    task automatic test_store_load;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if ({mem_write, mem_read} !== 2'b10 || mem_address !== 32'd10 || mem_write_data !== 32'h12345678) begin
            n_fails++; $display("FAIL store_strobe: wr/rd=%b addr=%0d wdata=%h want 10 10 12345678", {mem_write, mem_read}, mem_address, mem_write_data);
        end
        @(negedge clk);
        n_checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0 || mem_write !== 1'b0) begin
            n_fails++; $display("FAIL store_ack: ack=%b rdata=%h err=%b wr=%b want 1 0 0 0", d_ack, d_rdata, d_err, mem_write);
        end
        d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem[10] !== 32'h12345678) begin
            n_fails++; $display("FAIL store_commit: mem[10]=%h want 12345678", mem[10]);
        end
        d_req = 1'b1; d_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write} !== 2'b10 || mem_address !== 32'd10) begin
            n_fails++; $display("FAIL load_strobe: rd/wr=%b addr=%0d want 10 10", {mem_read, mem_write}, mem_address);
        end
        @(negedge clk);
        n_checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
            n_fails++; $display("FAIL load_ack: ack=%b rdata=%h want 1 12345678", d_ack, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd10;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'd5) begin
            n_fails++; $display("FAIL tie_first_grant: rd=%b addr=%0d want 1 5", mem_read, mem_address);
        end
        @(negedge clk);
        n_checks++;
        if ({i_ack, d_ack} !== 2'b10 || i_rdata !== 32'hDEADBEEF) begin
            n_fails++; $display("FAIL tie_fetch_ack: i/d ack=%b data=%h want 10 deadbeef", {i_ack, d_ack}, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'd10 || d_ack !== 1'b0) begin
            n_fails++; $display("FAIL tie_data_grant: rd=%b addr=%0d ack=%b want 1 10 0", mem_read, mem_address, d_ack);
        end
        @(negedge clk);
        n_checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
            n_fails++; $display("FAIL tie_data_ack: ack=%b rdata=%h want 1 12345678", d_ack, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_continuous;
        logic exp_i, exp_d;
        i_req = 1'b1; i_addr = 32'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd10;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_i = (c % 4 == 2);
            exp_d = (c >= 4) && (c % 4 == 0);
            n_checks++;
            if ({i_ack, d_ack} !== {exp_i, exp_d}) begin
                n_fails++; $display("FAIL continuous_ack c%0d: i/d ack=%b want %b", c, {i_ack, d_ack}, {exp_i, exp_d});
            end
            n_checks++;
            if ((mem_read & mem_write) !== 1'b0) begin
                n_fails++; $display("FAIL continuous_strobes c%0d: rd=%b wr=%b want not both", c, mem_read, mem_write);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_single_rerequest;
        i_req = 1'b1; i_addr = 32'd5;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_checks++;
            if (i_ack !== (c % 3 == 2)) begin
                n_fails++; $display("FAIL rerequest_ack c%0d: ack=%b want %b", c, i_ack, (c % 3 == 2));
            end
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_range_boundary;
        i_req = 1'b1; i_addr = 32'd255;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'd255) begin
            n_fails++; $display("FAIL range_255_strobe: rd=%b addr=%0d want 1 255", mem_read, mem_address);
        end
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'hA00000FF) begin
            n_fails++; $display("FAIL range_255_ack: ack=%b err=%b data=%h want 1 0 a00000ff", i_ack, i_err, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd256;
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_fails++; $display("FAIL range_256_strobe: rd/wr=%b want 00", {mem_read, mem_write});
        end
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'h0) begin
            n_fails++; $display("FAIL range_256_ack: ack=%b err=%b data=%h want 1 1 0", i_ack, i_err, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b0 || i_err !== 1'b1) begin
            n_fails++; $display("FAIL range_err_hold: ack=%b err=%b want 0 1", i_ack, i_err);
        end
    endtask

    task automatic test_oor_store;
        int diffs;
        for (int k = 0; k < DEPTH; k++) snap[k] = mem[k];
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd300; d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        n_checks++;
        if ({mem_write, mem_read} !== 2'b00) begin
            n_fails++; $display("FAIL oor_strobe: wr/rd=%b want 00", {mem_write, mem_read});
        end
        @(negedge clk);
        n_checks++;
        if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
            n_fails++; $display("FAIL oor_ack: ack=%b err=%b rdata=%h want 1 1 0", d_ack, d_err, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        diffs = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== snap[k]) diffs++;
        n_checks++;
        if (diffs != 0) begin
            n_fails++; $display("FAIL oor_memory: %0d words changed want 0", diffs);
        end
    endtask

    task automatic test_reset_during_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'h5555AAAA;
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fails++; $display("FAIL rst_store_strobe: wr=%b want 1", mem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || dut.state !== IDLE || d_ack !== 1'b0) begin
            n_fails++; $display("FAIL rst_store_clear: wr=%b state=%0d ack=%b want 0 0 0", mem_write, dut.state, d_ack);
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem[20] !== 32'hA0000014 || d_ack !== 1'b0) begin
            n_fails++; $display("FAIL rst_store_mem: mem[20]=%h ack=%b want a0000014 0", mem[20], d_ack);
        end
        rst_n = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd5;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hDEADBEEF || d_ack !== 1'b0) begin
            n_fails++; $display("FAIL rst_recover_fetch: ack=%b data=%h d_ack=%b want 1 deadbeef 0", i_ack, i_rdata, d_ack);
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        @(negedge clk);
        for (int k = 0; k < DEPTH; k++) preload(8'(k), 32'hA000_0000 | 32'(k));
        preload(8'd5, 32'hDEADBEEF);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_fetch();
        test_store_load();
        test_tie();
        test_continuous();
        test_single_rerequest();
        test_range_boundary();
        test_oor_store();
        test_reset_during_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported, word-addressed 256-entry `memory` block between the instruction-fetch unit and the load/store (data) unit of the multicycle MIPS core. Each requester uses a req/ack handshake. The arbiter grants the memory to one requester per access, drives the memory strobes for exactly one cycle, registers read data and returns it with a one-cycle `ack` pulse. Simultaneous requests are resolved round-robin, and out-of-range addresses are rejected without touching memory.

## Interface
- `DEPTH`, 256: number of memory words; valid addresses are 0..DEPTH-1.
- `AW`, 32: address and data width.

- `clk`  in  1  rising-edge clock shared with `memory`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high with `i_addr` stable until `i_ack`.
- `i_addr`  in  AW  fetch word address.
- `i_ack`  out  1  one-cycle completion pulse for fetch.
- `i_rdata`  out  AW  fetched word; valid while `i_ack` is high.
- `i_err`  out  1  address out of range; valid with `i_ack`.
- `d_req`  in  1  data request; held high with `d_we`, `d_addr` and `d_wdata` stable until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  AW  store data.
- `d_ack`  out  1  one-cycle completion pulse for data.
- `d_rdata`  out  AW  load data; valid with `d_ack`. Holds 0 for stores.
- `d_err`  out  1  address out of range; valid with `d_ack`.
- `mem_address`  out  AW  to `memory.address`.
- `mem_write_data`  out  AW  to `memory.writeData`.
- `mem_read`  out  1  to `memory.memRead`.
- `mem_write`  out  1  to `memory.memWrite`.
- `mem_data`  in  AW  from `memory.memData` (combinational read).

## Operation
- **States:** IDLE, GNT_I, GNT_D, RESP.
- **IDLE:** if any `req` is high, pick a winner and go to GNT_I or GNT_D. Otherwise stay in IDLE.
- **Arbitration:** round-robin on a `last` register.
  - If both ports request, grant the port that is not `last`.
  - A single requester is granted immediately.
  - `last` resets to D, so fetch wins the first tie.
  - `last` updates when a grant is issued.
- **GNT_x (one cycle):**
  - In range: drive `mem_address` from the granted port's address and assert `mem_read` (fetch, or data with `d_we`=0) or `mem_write` (data with `d_we`=1).
  - Out of range (`addr >= DEPTH`): both strobes stay 0 and an error flag is latched.
  - At the clock edge, register `mem_data` (or 0 on error or store) into the port's rdata register. A store commits in `memory` at this same edge.
  - Next state is RESP.
- **RESP:**
  - Pulse the granted port's `ack` together with its `rdata` and `err`.
  - Arbitration in this cycle ignores the acked port's `req`, because that requester drops `req` only after seeing `ack`.
  - If the other port requests, go directly to its GNT state. Otherwise go to IDLE.
- **Idle outputs:** `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_write_data`=0.
- **Output hold:** `rdata` and `err` hold their values after `ack` until the next access to that port.

## Timing
- **Reset values:** all outputs 0; state IDLE; `last`=D.
- **Latency:** `req` sampled in cycle 0, strobe in cycle 1, `ack` in cycle 2.
- **Throughput:** one access every 2 cycles under continuous alternating demand. A single port re-requesting gets one access per 3 cycles, since its `req` is ignored in its own RESP cycle.
- **Strobes:** `mem_read` and `mem_write` are never high together and are never high outside GNT states.
- **Store visibility:** a store completes at the end of GNT_D, so a load issued afterwards reads the new value.
- **Reset mid-operation:** `rst_n` low forces all outputs to 0 combinationally through the async clear, so an in-flight `mem_write` never reaches a clock edge. No `ack` is issued and no partial state survives.
- **Request withdrawal:** dropping `req` before `ack` is a protocol violation. The arbiter completes the access as latched in GNT.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum (IDLE, GNT_I, GNT_D, RESP)
  - port-id constants (`PORT_I`=0, `PORT_D`=1)
  - default `DEPTH`
- **Sub-module `rr_pick2`:** combinational 2-way round-robin selector. Inputs: two reqs, a mask, `last`. Outputs: `valid`, `winner`.
- **Top:** the FSM, registered outputs and the range check live in `mem_arbiter`.

## Test plan
- **Single fetch:** memory word 5 = 0xDEADBEEF; `i_req` with `i_addr`=5 in cycle 0. Expect `mem_read`=1 with `mem_address`=5 in cycle 1 only, then `i_ack`=1 with `i_rdata`=0xDEADBEEF and `i_err`=0 in cycle 2.
- **Store then load:** data store of 0x12345678 to address 10, then load from address 10. Expect `mem_write` high for exactly one cycle, then `d_rdata`=0x12345678.
- **Tie after reset:** `i_req` and `d_req` rise together. Expect fetch acked in cycle 2, data granted in cycle 3 (RESP→GNT_D) and acked in cycle 4.
- **Continuous demand:** both reqs held high for 20 cycles, with re-requests after each `ack`. Expect grants to strictly alternate and no port to go more than 4 cycles without an `ack`.
- **Out-of-range store:** `d_addr`=300, `d_we`=1, data 0xFFFFFFFF. Expect no `mem_write` pulse, `d_ack` with `d_err`=1 and `d_rdata`=0, and all 256 memory words unchanged.
- **Reset during store:** assert `rst_n`=0 mid-cycle during GNT_D of a store. Expect `mem_write` to fall immediately, the target word unchanged, no `d_ack`, state IDLE. After release, a new fetch completes normally.
